// File: rtl/scan_pkg.sv
// Shared constants for the multiplexed display scanner: parameter limits,
// counter widths and the hex 7-segment glyph table (gfedcba, active-high).
package scan_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int MIN_DIV    = 2;
  localparam int MAX_DIV    = 65535;
  localparam int CNT_W      = 16;
  localparam int IDX_W      = 3;

  typedef logic [6:0] seg7_t;

  // Entry n is the glyph for nibble n; the first element listed is nibble F.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/scan_display_gen_if.sv
// Bus between a digit source and the scanner: load-side inputs and the
// multiplexed display drive outputs.
interface scan_display_gen_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                      en;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic [NUM_DIGITS-1:0]     dp;
  logic                      lz_en;
  logic [NUM_DIGITS-1:0]     sel;
  logic [6:0]                seg;
  logic                      dp_out;
  logic                      frame_done;

  modport master (
    output en, load, digits, dp, lz_en,
    input  sel, seg, dp_out, frame_done
  );

  modport slave (
    input  en, load, digits, dp, lz_en,
    output sel, seg, dp_out, frame_done
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to 7-segment glyph lookup (gfedcba, active-high).
module seg7_decode
  import scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  assign seg_o = HEX_GLYPHS[nibble_i];

endmodule

// File: rtl/scan_display_gen.sv
// Time-multiplexed hex display scanner with double-buffered digit data,
// leading-zero suppression, per-slot dead time and registered outputs.
module scan_display_gen
  import scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV         = 32,
  parameter int BLANK       = 1,
  parameter int SEL_ACT_LOW = 0,
  parameter int SEG_ACT_LOW = 0
) (
  input logic               clk,
  input logic               rst,
  scan_display_gen_if.slave bus
);

  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]      LEFT_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE  = (SEL_ACT_LOW != 0) ? '1 : '0;
  localparam seg7_t                 SEG_IDLE  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_IDLE   = (SEG_ACT_LOW != 0);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS || DIV < MIN_DIV || DIV > MAX_DIV ||
      BLANK < 0 || BLANK > DIV - 1) begin : gBadParam
    $error("scan_display_gen: parameter out of legal range");
  end

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] bufDigits_q, dispDigits_q;
  logic [NUM_DIGITS-1:0]   bufDp_q, dispDp_q;
  logic                    bufLz_q, dispLz_q;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  seg7_t                   seg_q, seg_d;
  logic                    dpOut_q, dpOut_d;

  logic                    tick, frameEdge, inBlank, active, suppress, upperZero, dpSel;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   selOneHot;
  seg7_t                   glyph;

  assign tick      = bus.en && (cnt_q == LAST_CNT);
  assign frameEdge = tick && (idx_q == '0);

  if (BLANK == 0) begin : gNoBlank
    assign inBlank = 1'b0;
  end else begin : gBlank
    assign inBlank = (cnt_q < CNT_W'(BLANK));
  end

  assign active = bus.en && !inBlank;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (bus.en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        idx_d = (idx_q == '0) ? LEFT_IDX : idx_q - 1'b1;
      end
    end
  end

  // A digit is blanked only when it and every digit to its left are zero.
  always_comb begin
    nibble    = 4'h0;
    dpSel     = 1'b0;
    selOneHot = '0;
    upperZero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        nibble       = dispDigits_q[4*i +: 4];
        dpSel        = dispDp_q[i];
        selOneHot[i] = 1'b1;
      end
      if (IDX_W'(i) >= idx_q && dispDigits_q[4*i +: 4] != 4'h0) begin
        upperZero = 1'b0;
      end
    end
    suppress = dispLz_q && (idx_q != '0) && upperZero;
  end

  seg7_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  always_comb begin
    sel_d   = active ? selOneHot : '0;
    seg_d   = (active && !suppress) ? glyph : 7'h00;
    dpOut_d = active && dpSel;
  end

  // Polarity is applied only here, so all upstream logic stays active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= LEFT_IDX;
      bufDigits_q  <= '0;
      bufDp_q      <= '0;
      bufLz_q      <= 1'b0;
      dispDigits_q <= '0;
      dispDp_q     <= '0;
      dispLz_q     <= 1'b0;
      sel_q        <= SEL_IDLE;
      seg_q        <= SEG_IDLE;
      dpOut_q      <= DP_IDLE;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (bus.load) begin
        bufDigits_q <= bus.digits;
        bufDp_q     <= bus.dp;
        bufLz_q     <= bus.lz_en;
      end
      if (frameEdge) begin
        dispDigits_q <= bufDigits_q;
        dispDp_q     <= bufDp_q;
        dispLz_q     <= bufLz_q;
      end
      sel_q   <= sel_d ^ SEL_IDLE;
      seg_q   <= seg_d ^ SEG_IDLE;
      dpOut_q <= dpOut_d ^ DP_IDLE;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.seg        = seg_q;
  assign bus.dp_out     = dpOut_q;
  assign bus.frame_done = frameEdge;

endmodule

// File: tb/tb_scan_display_gen.sv
// Self-checking bench: an active-high and an active-low scanner share one
// stimulus stream and are compared every cycle against a frame-position model.
module tb_scan_display_gen;

  localparam int ND    = 4;
  localparam int DIVP  = 8;
  localparam int BLK   = 1;
  localparam int FRAME = ND * DIVP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        lzEn = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp = 4'h0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  scan_display_gen_if #(.NUM_DIGITS(ND)) busHi ();
  scan_display_gen_if #(.NUM_DIGITS(ND)) busLo ();

  assign busHi.en = en;
  assign busHi.load = load;
  assign busHi.digits = digits;
  assign busHi.dp = dp;
  assign busHi.lz_en = lzEn;
  assign busLo.en = en;
  assign busLo.load = load;
  assign busLo.digits = digits;
  assign busLo.dp = dp;
  assign busLo.lz_en = lzEn;

  scan_display_gen #(
    .NUM_DIGITS(ND), .DIV(DIVP), .BLANK(BLK), .SEL_ACT_LOW(0), .SEG_ACT_LOW(0)
  ) dutHi (
    .clk (clk),
    .rst (rst),
    .bus (busHi.slave)
  );

  scan_display_gen #(
    .NUM_DIGITS(ND), .DIV(DIVP), .BLANK(BLK), .SEL_ACT_LOW(1), .SEG_ACT_LOW(1)
  ) dutLo (
    .clk (clk),
    .rst (rst),
    .bus (busLo.slave)
  );

  function automatic logic [6:0] hexGlyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: position within the frame plus both data buffers
  int          pos = 0;
  logic [15:0] mBufDig = 0, mDispDig = 0;
  logic [3:0]  mBufDp = 0, mDispDp = 0;
  logic        mBufLz = 0, mDispLz = 0;
  logic [3:0]  expSel = 0, expSelLo = 4'hF;
  logic [6:0]  expSeg = 0, expSegLo = 7'h7F;
  logic        expDp = 0, expDpLo = 1;
  bit          modelValid = 0;

  always @(posedge clk) begin : modelProc
    int   idx;
    bit   act, sup, frame;
    if (rst) begin
      pos = 0;
      mBufDig = 0; mBufDp = 0; mBufLz = 0;
      mDispDig = 0; mDispDp = 0; mDispLz = 0;
      expSel = 0; expSeg = 0; expDp = 0;
      modelValid = 1;
    end else begin
      idx = ND - 1 - pos / DIVP;
      act = en && ((pos % DIVP) >= BLK);
      sup = mDispLz && (idx != 0) && ((mDispDig >> (4 * idx)) == 16'h0);
      expSel = act ? 4'(1 << idx) : 4'h0;
      expSeg = (act && !sup) ? hexGlyph(mDispDig[4*idx +: 4]) : 7'h00;
      expDp = act ? mDispDp[idx] : 1'b0;
      frame = en && (pos == FRAME - 1);
      if (frame) begin
        mDispDig = mBufDig; mDispDp = mBufDp; mDispLz = mBufLz;
      end
      if (load) begin
        mBufDig = digits; mBufDp = dp; mBufLz = lzEn;
      end
      if (en) pos = (pos + 1) % FRAME;
    end
    expSelLo = ~expSel;
    expSegLo = ~expSeg;
    expDpLo = ~expDp;
  end

  always @(negedge clk) begin
    #1;
    if (modelValid) begin
      checkOutput("selHi", 32'(busHi.sel), 32'(expSel));
      checkOutput("segHi", 32'(busHi.seg), 32'(expSeg));
      checkOutput("dpHi", 32'(busHi.dp_out), 32'(expDp));
      checkOutput("frameHi", 32'(busHi.frame_done), 32'(en && (pos == FRAME - 1)));
      checkOutput("selLo", 32'(busLo.sel), 32'(expSelLo));
      checkOutput("segLo", 32'(busLo.seg), 32'(expSegLo));
      checkOutput("dpLo", 32'(busLo.dp_out), 32'(expDpLo));
      checkOutput("frameLo", 32'(busLo.frame_done), 32'(en && (pos == FRAME - 1)));
    end
  end

  task automatic sampleTick;
    @(negedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic lz);
    digits = d;
    dp = p;
    lzEn = lz;
    load = 1'b1;
    sampleTick;
    load = 1'b0;
  endtask

  task automatic waitSel(input logic [3:0] want, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      sampleTick;
      if (busHi.sel === want) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("waitSelTimeout", 32'(busHi.sel), 32'(want));
  endtask

  task automatic waitFrameDone(output int n);
    bit ok;
    ok = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      sampleTick;
      n = i + 1;
      if (busHi.frame_done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("frameTimeout", 32'(busHi.frame_done), 32'h1);
  endtask

  task automatic checkSlot(input string name, input logic [3:0] selWant, input logic [6:0] segWant);
    bit ok;
    waitSel(selWant, ok);
    if (ok) checkOutput(name, 32'(busHi.seg), 32'(segWant));
  endtask

  initial begin
    bit ok;
    int n;
    int run;
    $display("[TB] start");
    repeat (3) sampleTick;
    checkOutput("rstSelHi", 32'(busHi.sel), 32'h0);
    checkOutput("rstSegHi", 32'(busHi.seg), 32'h0);
    checkOutput("rstSelLo", 32'(busLo.sel), 32'hF);
    checkOutput("rstSegLo", 32'(busLo.seg), 32'h7F);
    checkOutput("rstFrame", 32'(busHi.frame_done), 32'h0);
    rst = 1'b0;

    // Basic scan of 1234
    applyStimulus(16'h1234, 4'h0, 1'b0);
    en = 1'b1;
    waitFrameDone(n);
    waitFrameDone(n);
    checkOutput("framePeriod", 32'(n), 32'(FRAME));
    waitSel(4'b1000, ok);
    if (ok) begin
      checkOutput("seg1234_d3", 32'(busHi.seg), 32'(7'b0000110));
      run = 1;
      for (int i = 0; i < 20; i++) begin
        sampleTick;
        if (busHi.sel !== 4'b1000) break;
        run++;
      end
      checkOutput("activeCycles", 32'(run), 32'd7);
    end
    checkSlot("seg1234_d2", 4'b0100, 7'b1011011);
    checkSlot("seg1234_d1", 4'b0010, 7'b1001111);
    checkSlot("seg1234_d0", 4'b0001, 7'b1100110);

    // Leading-zero suppression
    applyStimulus(16'h0050, 4'h0, 1'b1);
    waitFrameDone(n);
    checkSlot("lz_d3", 4'b1000, 7'b0000000);
    checkSlot("lz_d2", 4'b0100, 7'b0000000);
    checkSlot("lz_d1", 4'b0010, 7'b1101101);
    checkSlot("lz_d0", 4'b0001, 7'b0111111);

    // Double buffering, including a load coincident with the frame boundary
    applyStimulus(16'hAAAA, 4'h0, 1'b0);
    waitFrameDone(n);
    checkSlot("dbA_d3", 4'b1000, 7'b1110111);
    applyStimulus(16'h5555, 4'h0, 1'b0);
    waitFrameDone(n);
    checkSlot("db5_d3", 4'b1000, 7'b1101101);
    applyStimulus(16'hAAAA, 4'h0, 1'b0);
    waitFrameDone(n);
    digits = 16'h5555;
    load = 1'b1;
    sampleTick;
    load = 1'b0;
    checkSlot("coinA_d3", 4'b1000, 7'b1110111);
    checkSlot("coinA_d0", 4'b0001, 7'b1110111);
    waitFrameDone(n);
    checkSlot("coin5_d3", 4'b1000, 7'b1101101);
    checkSlot("coin5_d0", 4'b0001, 7'b1101101);

    // Active-low outputs with an 8888 pattern
    applyStimulus(16'h8888, 4'b0001, 1'b0);
    waitFrameDone(n);
    waitSel(4'b1000, ok);
    if (ok) begin
      checkOutput("lowSel_d3", 32'(busLo.sel), 32'(4'b0111));
      checkOutput("lowSeg_d3", 32'(busLo.seg), 32'h0);
      checkOutput("lowDp_d3", 32'(busLo.dp_out), 32'h1);
    end
    waitSel(4'b0001, ok);
    if (ok) begin
      checkOutput("lowSeg_d0", 32'(busLo.seg), 32'h0);
      checkOutput("lowDp_d0", 32'(busLo.dp_out), 32'h0);
    end

    // Pause mid-slot
    waitSel(4'b0100, ok);
    sampleTick;
    sampleTick;
    en = 1'b0;
    sampleTick;
    checkOutput("pauseSelHi", 32'(busHi.sel), 32'h0);
    checkOutput("pauseSelLo", 32'(busLo.sel), 32'hF);
    repeat (19) sampleTick;
    en = 1'b1;

    // Mid-frame reset during idx 1
    applyStimulus(16'h1234, 4'h0, 1'b0);
    waitFrameDone(n);
    waitSel(4'b0010, ok);
    rst = 1'b1;
    sampleTick;
    checkOutput("midRstSel", 32'(busHi.sel), 32'h0);
    checkOutput("midRstSeg", 32'(busHi.seg), 32'h0);
    rst = 1'b0;
    sampleTick;
    checkOutput("postRstBlank", 32'(busHi.sel), 32'h0);
    sampleTick;
    checkOutput("postRstSel", 32'(busHi.sel), 32'(4'b1000));
    checkOutput("postRstSeg", 32'(busHi.seg), 32'(7'b0111111));

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      sampleTick;
      load = ($urandom_range(0, 11) == 0);
      digits = 16'($urandom) >> (4 * $urandom_range(0, 3));
      dp = 4'($urandom);
      lzEn = 1'($urandom);
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
    end
    load = 1'b0;
    rst = 1'b0;
    repeat (4) sampleTick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/scan_display_gen.md
SCAN_DISPLAY_GEN -- requirements
Module: scan_display_gen

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL provide DIV, default 32: clk cycles per digit slot, legal range 2..65535.
REQ-003 SHALL provide BLANK, default 1: dead-time cycles at the start of each slot, legal range 0..DIV-1.
REQ-004 SHALL provide SEL_ACT_LOW, default 0: 1 = select outputs active-low.
REQ-005 SHALL provide SEG_ACT_LOW, default 0: 1 = segment and dp outputs active-low.

Ports (name, direction, width, meaning):
REQ-006 SHALL provide clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL provide rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL provide en, input, 1: scan enable.
REQ-009 SHALL provide load, input, 1: one-cycle strobe that captures digits, dp and lz_en.
REQ-010 SHALL provide digits, input, 4*NUM_DIGITS: hex nibbles; digit i = digits[4i+3:4i], digit NUM_DIGITS-1 is leftmost.
REQ-011 SHALL provide dp, input, NUM_DIGITS: decimal point per digit.
REQ-012 SHALL provide lz_en, input, 1: leading-zero suppression enable.
REQ-013 SHALL provide sel, output, NUM_DIGITS: one-hot digit select.
REQ-014 SHALL provide seg, output, 7: segments {g,f,e,d,c,b,a}.
REQ-015 SHALL provide dp_out, output, 1: decimal point of the selected digit.
REQ-016 SHALL provide frame_done, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-017 SHALL run slot counter cnt 0..DIV-1 while en=1; it wraps to 0 after DIV-1, and the cycle with cnt==DIV-1 is the tick.
REQ-018 SHALL step digit index idx on each tick from NUM_DIGITS-1 down to 0, then wrap to NUM_DIGITS-1.
REQ-019 SHALL treat the tick with idx==0 as the frame boundary: copy the load buffer into the display register and assert frame_done for exactly that cycle.
REQ-020 SHALL capture digits/dp/lz_en into the load buffer on load=1; the display register changes only at a frame boundary (glitch-free double buffering).
REQ-021 SHALL, when load coincides with a frame boundary, let the display register take the previous buffer contents; the new data appears from the next frame.
REQ-022 SHALL, with lz_en=1 (display copy), blank digit i if its nibble and all nibbles above it are 0; digit 0 is never suppressed, and a suppressed digit's dp is still shown.
REQ-023 SHALL decode nibbles 0-F to standard 7-segment hex glyphs (e.g. 0 -> 0111111, 8 -> 1111111, F -> 1110001, in gfedcba order, active-high form).
REQ-024 SHALL drive sel, seg and dp_out inactive while cnt < BLANK.
REQ-025 SHALL register sel, seg and dp_out with one cycle of latency from (cnt, idx); otherwise sel has exactly one active bit, the one for idx.
REQ-026 SHALL, when en=0, hold cnt and idx, drive sel/seg/dp_out inactive one cycle later, and keep frame_done at 0; load is still accepted.
REQ-027 SHALL apply polarity inversion only at the output registers, per SEL_ACT_LOW and SEG_ACT_LOW.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, set cnt=0, idx=NUM_DIGITS-1, load buffer=0, display register=0 and frame_done=0, and drive sel/seg/dp_out inactive.
REQ-029 SHALL take reset priority over en and load, and a mid-frame reset SHALL restart scanning at the leftmost digit after release.

Structure
REQ-030 SHALL place the 7-segment glyph constants and the parameter-limit constants in shared package scan_pkg.
REQ-031 SHALL implement hex-to-segment decoding as sub-module seg7_decode (combinational, 4-bit in, 7-bit out), instantiated once on the selected nibble.

Verification
(Common setup: NUM_DIGITS=4, DIV=8, BLANK=1, active-high unless stated.)
REQ-032 SHALL cover: reset, load digits=16'h1234, dp=0, lz_en=0, en=1 -> after the first frame boundary, sel 1000/0100/0010/0001 with seg 0000110/1011011/1001111/1100110, each active 7 of 8 cycles, and frame_done every 32 cycles.
REQ-033 SHALL cover: digits=16'h0050, lz_en=1 -> digits 3 and 2 blank (seg 0000000), digit 1 shows 1101101, digit 0 shows 0111111.
REQ-034 SHALL cover: load 16'hAAAA, then 16'h5555 mid-frame and again exactly at a frame-boundary cycle -> no frame ever shows mixed digits, and the coincident load appears one frame later.
REQ-035 SHALL cover: SEL_ACT_LOW=1, SEG_ACT_LOW=1, digits=16'h8888, dp=4'b0001 -> seg 0000000 when active, dp_out=0 only in the idx 0 slot, and idle sel=1111.
REQ-036 SHALL cover: en=0 for 20 cycles mid-slot -> outputs inactive and cnt/idx frozen; after en=1, scanning resumes from the same slot and count.
REQ-037 SHALL cover: rst=1 for one cycle during idx=1 -> next cycle outputs inactive, display register 0, and the first active slot after release selects 1000 with digit 0 glyph 0111111.
